// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: one outstanding imem read at a time,
// hands fetched words to decode and drives the PC register load port.
module instr_fetch_unit #(
    parameter int XLEN    = 32,
    parameter int PC_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_q,
    output logic            pc_ld,
    output logic [XLEN-1:0] pc_next,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    logic [1:0]      state_q, state_d;
    logic            drop_q, drop_d;
    logic            inst_valid_q, inst_valid_d;
    logic [XLEN-1:0] inst_data_q, inst_data_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            inst_fire;

    assign imem_req_addr  = pc_q;
    assign imem_req_valid = (state_q == S_REQ) & ~redirect_valid & ~rst;
    assign inst_fire      = inst_valid_q & inst_ready;

    assign inst_valid = inst_valid_q;
    assign inst_data  = inst_data_q;
    assign inst_pc    = inst_pc_q;

    // Redirect wins over the sequential advance of an accepted instruction.
    always_comb begin
        pc_ld   = 1'b0;
        pc_next = pc_q;
        if (redirect_valid) begin
            pc_ld   = 1'b1;
            pc_next = redirect_pc;
        end else if (inst_fire) begin
            pc_ld   = 1'b1;
            pc_next = inst_pc_q + STEP;
        end
        if (rst) begin
            pc_ld = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        drop_d       = drop_q;
        inst_valid_d = inst_valid_q;
        inst_data_d  = inst_data_q;
        inst_pc_d    = inst_pc_q;
        req_pc_d     = req_pc_q;
        case (state_q)
            S_REQ: begin
                if (imem_req_valid && imem_req_ready) begin
                    req_pc_d = pc_q;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (drop_q || redirect_valid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_data_d  = imem_rsp_data;
                        inst_pc_d    = req_pc_q;
                        inst_valid_d = 1'b1;
                        state_d      = S_OUT;
                    end
                end else if (redirect_valid) begin
                    // The in-flight response now belongs to a dead path.
                    drop_d = 1'b1;
                end
            end
            S_OUT: begin
                if (redirect_valid || inst_fire) begin
                    inst_valid_d = 1'b0;
                    state_d      = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            drop_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_data_q  <= '0;
            inst_pc_q    <= '0;
            req_pc_q     <= '0;
        end else begin
            state_q      <= state_d;
            drop_q       <= drop_d;
            inst_valid_q <= inst_valid_d;
            inst_data_q  <= inst_data_d;
            inst_pc_q    <= inst_pc_d;
            req_pc_q     <= req_pc_d;
        end
    end

endmodule
